cla_32bit: RTL and testbench



---
 rtl/cla_32bit_pkg.sv | 20 ++
 rtl/cla_4bit.sv | 24 ++
 rtl/cla_32bit.sv | 80 ++++++++
 tb/tb_cla_32bit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_32bit_pkg.sv
// rtl/cla_32bit_pkg.sv - flat 4-wide look-ahead equations shared by every CLA level
package cla_32bit_pkg;

    // Carries into positions 0..3 of a 4-wide group, as flat sum-of-products.
    function automatic logic [3:0] la_carry(input logic [2:0] p, input logic [2:0] g,
                                            input logic c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    // Group generate of a 4-wide group; bit 0 propagate never matters here.
    function automatic logic la_gen(input logic [3:1] p, input logic [3:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/cla_4bit.sv
// rtl/cla_4bit.sv - 4-bit look-ahead block with block propagate/generate
module cla_4bit
    import cla_32bit_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       P,
    output logic       G
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p   = a ^ b;
    assign g   = a & b;
    assign c   = la_carry(p[2:0], g[2:0], cin);
    assign sum = p ^ c;
    assign P   = &p;
    assign G   = la_gen(p[3:1], g);

endmodule

// File: rtl/cla_32bit.sv
// rtl/cla_32bit.sv - N-bit carry look-ahead adder with registered sum, carry and group P/G
module cla_32bit
    import cla_32bit_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         Pout,
    output logic         Gout
);

    localparam int BW = 4;
    localparam int NB = N / BW;
    localparam int NG = NB / 4;

    logic [NB-1:0] blk_p;
    logic [NB-1:0] blk_g;
    logic [NB-1:0] blk_c;
    logic [NG-1:0] grp_p;
    logic [NG-1:0] grp_g;
    logic [NG-1:0] grp_c;
    logic [N-1:0]  sum_c;
    logic          pout_c;
    logic          gout_c;
    logic          cout_c;

    generate
        for (genvar i = 0; i < NB; i++) begin : g_blk
            cla_4bit u_blk (
                .a   (a[i*BW +: BW]),
                .b   (b[i*BW +: BW]),
                .cin (blk_c[i]),
                .sum (sum_c[i*BW +: BW]),
                .P   (blk_p[i]),
                .G   (blk_g[i])
            );
        end

        // Second level: each group of four blocks spans 16 bits.
        for (genvar j = 0; j < NG; j++) begin : g_grp
            assign grp_p[j]         = &blk_p[j*4 +: 4];
            assign grp_g[j]         = la_gen(blk_p[j*4+1 +: 3], blk_g[j*4 +: 4]);
            assign blk_c[j*4 +: 4]  = la_carry(blk_p[j*4 +: 3], blk_g[j*4 +: 3], grp_c[j]);
        end

        // Third level only exists once there is more than one 16-bit group.
        if (NG == 1) begin : g_top1
            assign grp_c[0] = cin;
            assign gout_c   = grp_g[0];
        end else begin : g_top2
            assign grp_c[0] = cin;
            assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
            assign gout_c   = grp_g[1] | (grp_p[1] & grp_g[0]);
        end
    endgenerate

    assign pout_c = &grp_p;
    assign cout_c = gout_c | (pout_c & cin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            Pout <= 1'b0;
            Gout <= 1'b0;
        end else begin
            sum  <= sum_c;
            cout <= cout_c;
            Pout <= pout_c;
            Gout <= gout_c;
        end
    end

endmodule

// File: tb/tb_cla_32bit.sv
// tb/tb_cla_32bit.sv - self-checking bench for cla_32bit at N=32 and N=16
module tb_cla_32bit;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        p;
        logic        g;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a32, b32, sum32;
    logic        cin32, cout32, p32, g32;
    logic [15:0] a16, b16, sum16;
    logic        cin16, cout16, p16, g16;

    int checks = 0;
    int errors = 0;

    vec_t t32[7];
    vec_t t16[4];

    always #5 clk = ~clk;

    cla_32bit #(.N(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .cin(cin32),
        .sum(sum32), .cout(cout32), .Pout(p32), .Gout(g32)
    );

    cla_32bit #(.N(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16),
        .sum(sum16), .cout(cout16), .Pout(p16), .Gout(g16)
    );

    task automatic cmp32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic cmp1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic, independent of any carry structure.
    task automatic check32(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic c);
        logic [32:0] full;
        logic [32:0] nocin;
        full  = {1'b0, a} + {1'b0, b} + {32'd0, c};
        nocin = {1'b0, a} + {1'b0, b};
        cmp32({tag, " sum32"}, sum32, full[31:0]);
        cmp1({tag, " cout32"}, cout32, full[32]);
        cmp1({tag, " pout32"}, p32, &(a ^ b));
        cmp1({tag, " gout32"}, g32, nocin[32]);
        cmp1({tag, " inv32"}, cout32, g32 | (p32 & c));
    endtask

    task automatic check16(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic c);
        logic [16:0] full;
        logic [16:0] nocin;
        full  = {1'b0, a} + {1'b0, b} + {16'd0, c};
        nocin = {1'b0, a} + {1'b0, b};
        cmp32({tag, " sum16"}, {16'd0, sum16}, {16'd0, full[15:0]});
        cmp1({tag, " cout16"}, cout16, full[16]);
        cmp1({tag, " pout16"}, p16, &(a ^ b));
        cmp1({tag, " gout16"}, g16, nocin[16]);
        cmp1({tag, " inv16"}, cout16, g16 | (p16 & c));
    endtask

    task automatic check_zero(input string tag);
        cmp32({tag, " sum32"}, sum32, 32'd0);
        cmp1({tag, " cout32"}, cout32, 1'b0);
        cmp1({tag, " pout32"}, p32, 1'b0);
        cmp1({tag, " gout32"}, g32, 1'b0);
        cmp32({tag, " sum16"}, {16'd0, sum16}, 32'd0);
        cmp1({tag, " cout16"}, cout16, 1'b0);
        cmp1({tag, " pout16"}, p16, 1'b0);
        cmp1({tag, " gout16"}, g16, 1'b0);
    endtask

    initial begin
        logic [31:0] pa, pb;
        logic        pc;
        logic [15:0] qa, qb;
        logic        qc;

        t32[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0};
        t32[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        t32[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
        t32[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        t32[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1};
        t32[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        t32[6] = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 32'h2143_6587, 1'b0, 1'b0, 1'b0};
        t16[0] = '{32'h0001, 32'h0002, 1'b0, 32'h0003, 1'b0, 1'b0, 1'b0};
        t16[1] = '{32'hFFFF, 32'h0000, 1'b1, 32'h0000, 1'b1, 1'b1, 1'b0};
        t16[2] = '{32'hFFFF, 32'h0000, 1'b0, 32'hFFFF, 1'b0, 1'b1, 1'b0};
        t16[3] = '{32'h8000, 32'h8000, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        a32 = '0; b32 = '0; cin32 = 1'b0;
        a16 = '0; b16 = '0; cin16 = 1'b0;

        // Reset held with toggling inputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
            check_zero($sformatf("reset[%0d]", i));
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a32 = t32[i].a; b32 = t32[i].b; cin32 = t32[i].cin;
            @(negedge clk);
            cmp32($sformatf("dir32[%0d] sum", i), sum32, t32[i].sum);
            cmp1($sformatf("dir32[%0d] cout", i), cout32, t32[i].cout);
            cmp1($sformatf("dir32[%0d] pout", i), p32, t32[i].p);
            cmp1($sformatf("dir32[%0d] gout", i), g32, t32[i].g);
        end

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a16 = t16[i].a[15:0]; b16 = t16[i].b[15:0]; cin16 = t16[i].cin;
            @(negedge clk);
            cmp32($sformatf("dir16[%0d] sum", i), {16'd0, sum16}, t16[i].sum);
            cmp1($sformatf("dir16[%0d] cout", i), cout16, t16[i].cout);
            cmp1($sformatf("dir16[%0d] pout", i), p16, t16[i].p);
            cmp1($sformatf("dir16[%0d] gout", i), g16, t16[i].g);
        end

        // Streaming 31-bit operands: no overflow possible.
        pa = '0; pb = '0;
        for (int i = 0; i <= 1000; i++) begin
            @(negedge clk);
            if (i > 0) begin
                cmp32($sformatf("rnd31[%0d] sum", i), sum32, pa + pb);
                cmp1($sformatf("rnd31[%0d] cout", i), cout32, 1'b0);
            end
            if (i < 1000) begin
                pa = $urandom & 32'h7FFF_FFFF;
                pb = $urandom & 32'h7FFF_FFFF;
                a32 = pa; b32 = pb; cin32 = 1'b0;
            end
        end

        // Streaming full-width operands with random carry-in on both widths.
        pc = 1'b0; qa = '0; qb = '0; qc = 1'b0;
        for (int i = 0; i <= 1000; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check32($sformatf("rnd32[%0d]", i), pa, pb, pc);
                check16($sformatf("rnd16[%0d]", i), qa, qb, qc);
            end
            if (i < 1000) begin
                pa = $urandom; pb = $urandom; pc = 1'($urandom);
                qa = 16'($urandom); qb = 16'($urandom); qc = 1'($urandom);
                a32 = pa; b32 = pb; cin32 = pc;
                a16 = qa; b16 = qb; cin16 = qc;
            end
        end

        // Asynchronous reset dropped between edges, then released mid-cycle.
        @(negedge clk);
        a32 = 32'd5; b32 = 32'd7; cin32 = 1'b1;
        a16 = 16'h00FF; b16 = 16'h0001; cin16 = 1'b0;
        @(posedge clk);
        #1;
        check32("pre_rst", 32'd5, 32'd7, 1'b1);
        check16("pre_rst", 16'h00FF, 16'h0001, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_clr");
        @(negedge clk);
        a32 = 32'hFFFF_FFFF; b32 = 32'h0; cin32 = 1'b1;
        a16 = 16'h8000; b16 = 16'h8000; cin16 = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        check_zero("post_release");
        @(posedge clk);
        #1;
        check32("first_after_rst", 32'hFFFF_FFFF, 32'h0, 1'b1);
        check16("first_after_rst", 16'h8000, 16'h8000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
